// File: rtl/ram16_8bit_loader.sv
// ram16_8bit_loader: 16x8 program memory filled over a valid/ready byte
// stream by a three-state load-session FSM, then read by the CPU through a
// ROM-compatible address / active-low output-enable port.
//
// Handshake: a byte transfers on a rising edge where wr_valid && wr_ready.
// wr_ready is high only in LOAD. A transfer never depends on wr_ready being
// combinationally derived from wr_valid.
module ram16_8bit_loader (
  input  logic       clk,
  input  logic       low_rst,
  input  logic       start,
  input  logic       end_load,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       load_busy,
  output logic       load_done,
  output logic [4:0] count,
  input  logic [3:0] addr,
  input  logic       low_o_en,
  output logic [7:0] data_out,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wptr;
  logic [7:0]  mem [16];
  logic        xfer;
  logic        last_xfer;
  logic        begin_session;

  assign xfer          = wr_valid && (state == LOAD);
  assign last_xfer     = xfer && (count == 5'd15);
  assign begin_session = start && (state != LOAD);

  // State register; reset aborts any session at once.
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and decoded status outputs.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        wr_ready  = 1'b1;
        load_busy = 1'b1;
        // A byte arriving with end_load is still written and counted.
        if (last_xfer || end_load) state_next = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        if (start) state_next = LOAD;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write pointer and byte count; both restart with every new session.
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      wptr  <= 4'd0;
      count <= 5'd0;
    end else if (begin_session) begin
      wptr  <= 4'd0;
      count <= 5'd0;
    end else if (xfer) begin
      // wptr wraps to 0 on the 16th byte, just as the FSM leaves LOAD.
      wptr  <= wptr + 4'd1;
      count <= count + 5'd1;
    end
  end

  // Memory array; cleared by reset, otherwise only touched by transfers.
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (xfer) begin
      mem[wptr] <= wr_data;
    end
  end

  // Read port: never drive a half-written program onto the bus.
  assign data_out  = (!low_o_en && (state != LOAD)) ? mem[addr] : 8'hzz;
  assign state_dbg = state;

endmodule

// File: tb/tb_ram16_8bit_loader.sv
// Bench for ram16_8bit_loader: directed sessions from the test plan plus
// randomized sessions, checked every cycle against a behavioural model.
module tb_ram16_8bit_loader;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       low_rst;
  logic       start;
  logic       end_load;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic [3:0] addr;
  logic       low_o_en;
  wire        wr_ready;
  wire        load_busy;
  wire        load_done;
  wire  [4:0] count;
  wire  [7:0] data_out;
  wire  [1:0] state_dbg;

  ram16_8bit_loader dut (
    .clk       (clk),
    .low_rst   (low_rst),
    .start     (start),
    .end_load  (end_load),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .load_busy (load_busy),
    .load_done (load_done),
    .count     (count),
    .addr      (addr),
    .low_o_en  (low_o_en),
    .data_out  (data_out),
    .state_dbg (state_dbg)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         check_en = 1'b0;

  // Behavioural model: a session flag, a done flag, a byte counter and an
  // array. Bytes are appended in order; the session closes at 16 bytes or
  // on end_load.
  bit         m_loading;
  bit         m_done;
  int         m_cnt;
  logic [7:0] m_mem [16];

  always @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      m_loading = 0;
      m_done    = 0;
      m_cnt     = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else if (m_loading) begin
      if (wr_valid) begin
        m_mem[m_cnt % 16] = wr_data;
        m_cnt = m_cnt + 1;
      end
      if (m_cnt == 16 || end_load) begin
        m_loading = 0;
        m_done    = 1;
      end
    end else if (start) begin
      m_loading = 1;
      m_done    = 0;
      m_cnt     = 0;
    end
  end

  // Compare helpers
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A released bus reads as z; two-state simulation collapses it to 0.
  task automatic chk_rel(input string name, input logic [7:0] act);
    n_checks++;
    if (!(act === 8'hzz || act === 8'h00)) begin
      n_fail++;
      $display("FAIL %s: got %h, expected released bus (zz) at %0t", name, act, $time);
    end
  endtask

  // Per-cycle compare process against the model.
  always @(negedge clk) begin
    if (check_en && low_rst) begin
      chk("wr_ready",  {7'd0, wr_ready},  {7'd0, m_loading});
      chk("load_busy", {7'd0, load_busy}, {7'd0, m_loading});
      chk("load_done", {7'd0, load_done}, {7'd0, m_done});
      chk("count",     {3'd0, count},     8'(m_cnt));
      if (low_o_en || m_loading) chk_rel("data_out_released", data_out);
      else chk("data_out", data_out, m_mem[addr]);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    end_load = last;
    tick();
    wr_valid = 1'b0;
    end_load = 1'b0;
  endtask

  // Read one address and compare with the oldest literal expectation.
  task automatic read_q(input logic [3:0] a);
    logic [7:0] e;
    addr     = a;
    low_o_en = 1'b0;
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL readback_queue: got empty queue, expected an entry");
    end else begin
      n_checks--;
      e = exp_q.pop_front();
      chk($sformatf("readback[%0d]", a), data_out, e);
    end
  endtask

  task automatic random_session();
    do_start();
    for (int c = 0; c < 100 && m_loading; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom);
      end_load = (c > 10) && ($urandom_range(0, 7) == 0);
      low_o_en = 1'($urandom_range(0, 1));
      addr     = 4'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    end_load = 1'b0;
    if (m_loading) begin
      end_load = 1'b1;
      tick();
      end_load = 1'b0;
    end
    chk("random_session_done", {7'd0, load_done}, 8'd1);
    for (int r = 0; r < 24; r++) begin
      addr     = 4'($urandom);
      low_o_en = 1'($urandom_range(0, 3) == 0);
      tick();
    end
  endtask

  initial begin
    low_rst  = 1'b0;
    start    = 1'b0;
    end_load = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    addr     = 4'd0;
    low_o_en = 1'b1;

    // Reset state
    #12;
    chk("rst_wr_ready",  {7'd0, wr_ready},  8'd0);
    chk("rst_load_busy", {7'd0, load_busy}, 8'd0);
    chk("rst_load_done", {7'd0, load_done}, 8'd0);
    chk("rst_count",     {3'd0, count},     8'd0);
    chk_rel("rst_data_out_disabled", data_out);
    #11 low_rst = 1'b1;
    tick();
    check_en = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) read_q(4'(i));

    // Full back-to-back load 10..1F
    low_o_en = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h10 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("full_load_done", {7'd0, load_done}, 8'd1);
    chk("full_count",     {3'd0, count},     8'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 16; i++) read_q(4'(i));

    // Load with bubbles A0..AF, bus must stay released with low_o_en = 0
    do_start();
    for (int c = 0; c < 32; c++) begin
      wr_valid = c[0];
      wr_data  = 8'hA0 + 8'(c / 2);
      low_o_en = 1'b0;
      addr     = 4'(c / 2);
      #1;
      if (c == 31) chk("bubble_not_done_early", {7'd0, load_done}, 8'd0);
      chk_rel("bubble_bus_released", data_out);
      tick();
    end
    wr_valid = 1'b0;
    chk("bubble_load_done", {7'd0, load_done}, 8'd1);
    chk("bubble_count",     {3'd0, count},     8'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) read_q(4'(i));

    // Early end with the third byte
    do_start();
    write_byte(8'h55, 1'b0);
    write_byte(8'h66, 1'b0);
    write_byte(8'h77, 1'b1);
    chk("early_count", {3'd0, count}, 8'd3);
    chk("early_done",  {7'd0, load_done}, 8'd1);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h77);
    for (int i = 3; i < 16; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) read_q(4'(i));

    // Writes and end_load in DONE are ignored
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    end_load = 1'b1;
    repeat (3) tick();
    wr_valid = 1'b0;
    end_load = 1'b0;
    chk("done_ignore_count", {3'd0, count}, 8'd3);
    exp_q.push_back(8'h55);
    read_q(4'd0);
    exp_q.push_back(8'h77);
    read_q(4'd2);
    exp_q.push_back(8'hA3);
    read_q(4'd3);

    // Reload a single byte
    do_start();
    write_byte(8'h01, 1'b0);
    chk("reload_count", {3'd0, count}, 8'd1);
    end_load = 1'b1;
    tick();
    end_load = 1'b0;
    exp_q.push_back(8'h01);
    read_q(4'd0);
    exp_q.push_back(8'h66);
    read_q(4'd1);

    // Randomized sessions
    repeat (3) random_session();

    // Reset mid-load: after 5 writes drop reset between edges
    do_start();
    for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i), 1'b0);
    #3 low_rst = 1'b0;
    #1;
    chk("midrst_count",     {3'd0, count},     8'd0);
    chk("midrst_load_busy", {7'd0, load_busy}, 8'd0);
    chk("midrst_wr_ready",  {7'd0, wr_ready},  8'd0);
    chk("midrst_load_done", {7'd0, load_done}, 8'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) read_q(4'(i));
    #2 low_rst = 1'b1;
    tick();
    repeat (2) tick();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
